// File: rtl/host_int_pipe_skid_n.sv
// host_int_pipe_skid_n: chain of STAGES fully-registered valid/ready skid slices
// (main + skid entry each), with synchronous flush and occupancy/idle reporting.
module host_int_pipe_skid_n #(
    parameter int DW     = 2,
    parameter int STAGES = 1,
    parameter int CW     = $clog2(2*STAGES+1)
) (
    input  logic          sysclk_slcg,
    input  logic          reset_,
    input  logic          i_pvld,
    output logic          i_prdy,
    input  logic [DW-1:0] i_pd,
    output logic          o_pvld,
    input  logic          o_prdy,
    output logic [DW-1:0] o_pd,
    input  logic          flush,
    output logic [CW-1:0] occ,
    output logic          i_idle
);

    // Boundary k feeds slice k; boundary STAGES is the block output.
    logic [STAGES:0] bnd_vld;
    logic [STAGES:0] bnd_rdy;
    logic [DW-1:0]   bnd_pd [STAGES+1];

    assign bnd_vld[0]      = i_pvld;
    assign bnd_pd[0]       = i_pd;
    assign bnd_rdy[STAGES] = o_prdy;

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        logic          main_v_q, main_v_d;
        logic          skid_v_q, skid_v_d;
        logic [DW-1:0] main_pd_q, main_pd_d;
        logic [DW-1:0] skid_pd_q, skid_pd_d;
        logic          accept;

        // Ready depends only on the registered skid flag, never on bnd_rdy[k+1].
        assign bnd_rdy[k]   = !skid_v_q;
        assign accept       = bnd_vld[k] && !skid_v_q;
        assign bnd_vld[k+1] = main_v_q;
        assign bnd_pd[k+1]  = main_pd_q;

        always_comb begin
            // NOTE: every signal written here gets a hold default first, so no latch is inferred.
            main_v_d  = main_v_q;
            skid_v_d  = skid_v_q;
            main_pd_d = main_pd_q;
            skid_pd_d = skid_pd_q;
            if (bnd_rdy[k+1] || !main_v_q) begin
                main_v_d = skid_v_q || accept;
                skid_v_d = 1'b0;
                if (skid_v_q) begin
                    main_pd_d = skid_pd_q;
                end else if (accept) begin
                    main_pd_d = bnd_pd[k];
                end
            end else if (accept) begin
                skid_v_d  = 1'b1;
                skid_pd_d = bnd_pd[k];
            end
            // Flush discards entries but leaves payload registers as they were.
            if (flush) begin
                main_v_d  = 1'b0;
                skid_v_d  = 1'b0;
                main_pd_d = main_pd_q;
                skid_pd_d = skid_pd_q;
            end
        end

        always_ff @(posedge sysclk_slcg or negedge reset_) begin
            if (!reset_) begin
                // NOTE: payload registers are reset too, so o_pd reads 0 straight out of reset.
                main_v_q  <= 1'b0;
                skid_v_q  <= 1'b0;
                main_pd_q <= '0;
                skid_pd_q <= '0;
            end else begin
                // NOTE: sequential state always uses non-blocking assignment.
                main_v_q  <= main_v_d;
                skid_v_q  <= skid_v_d;
                main_pd_q <= main_pd_d;
                skid_pd_q <= skid_pd_d;
            end
        end
    end

    assign i_prdy = bnd_rdy[0];
    assign o_pvld = bnd_vld[STAGES];
    assign o_pd   = bnd_pd[STAGES];

    logic          in_fire;
    logic          out_fire;
    logic [CW-1:0] occ_q, occ_d;

    assign in_fire  = i_pvld && i_prdy;
    assign out_fire = o_pvld && o_prdy;

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (in_fire && !out_fire) begin
            occ_d = occ_q + CW'(1);
        end else if (!in_fire && out_fire) begin
            occ_d = occ_q - CW'(1);
        end
    end

    always_ff @(posedge sysclk_slcg or negedge reset_) begin
        if (!reset_) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occ    = occ_q;
    assign i_idle = (occ_q == '0);

endmodule

// File: tb/tb_host_int_pipe_skid_n.sv
// Self-checking bench for host_int_pipe_skid_n: directed scenarios plus a random
// stall run scored against a FIFO-queue reference model.
module tb_host_int_pipe_skid_n;

    localparam int DW     = 8;
    localparam int STAGES = 2;
    localparam int CW     = $clog2(2*STAGES+1);
    localparam int CAP    = 2*STAGES;

    logic          sysclk_slcg = 1'b0;
    logic          reset_;
    logic          i_pvld;
    logic          i_prdy;
    logic [DW-1:0] i_pd;
    logic          o_pvld;
    logic          o_prdy;
    logic [DW-1:0] o_pd;
    logic          flush;
    logic [CW-1:0] occ;
    logic          i_idle;

    host_int_pipe_skid_n #(.DW(DW), .STAGES(STAGES)) dut (
        .sysclk_slcg(sysclk_slcg),
        .reset_     (reset_),
        .i_pvld     (i_pvld),
        .i_prdy     (i_prdy),
        .i_pd       (i_pd),
        .o_pvld     (o_pvld),
        .o_prdy     (o_prdy),
        .o_pd       (o_pd),
        .flush      (flush),
        .occ        (occ),
        .i_idle     (i_idle)
    );

    always #5 sysclk_slcg = ~sysclk_slcg;

    int total = 0;
    int bad   = 0;

    // Reference model: accepted beats, emitted beats, and entries held.
    logic [DW-1:0] acc_q[$];
    logic [DW-1:0] em_q[$];
    int            model_occ = 0;
    bit            last_acc;
    bit            last_emit;

    // Records the handshakes that happen at the coming edge, then advances one cycle.
    task automatic cycle();
        last_acc  = i_pvld && i_prdy;
        last_emit = o_pvld && o_prdy;
        if (last_acc && !flush) acc_q.push_back(i_pd);
        if (last_emit) em_q.push_back(o_pd);
        if (flush) model_occ = 0;
        else model_occ = model_occ + int'(last_acc) - int'(last_emit);
        @(posedge sysclk_slcg);
        #1;
    endtask

    task automatic clear_log();
        acc_q.delete();
        em_q.delete();
    endtask

    task automatic fill(input int n, input logic [DW-1:0] base);
        int sent = 0;
        o_prdy = 1'b0;
        flush  = 1'b0;
        for (int c = 0; c < 8*n && sent < n; c++) begin
            i_pvld = 1'b1;
            i_pd   = base + DW'(sent);
            cycle();
            if (last_acc) sent++;
        end
        i_pvld = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (i_prdy !== 1'b1) begin bad++; $display("FAIL reset_i_prdy got=%b want=1", i_prdy); end
        total++; if (o_pvld !== 1'b0) begin bad++; $display("FAIL reset_o_pvld got=%b want=0", o_pvld); end
        total++; if (o_pd !== '0) begin bad++; $display("FAIL reset_o_pd got=%h want=0", o_pd); end
        total++; if (occ !== '0) begin bad++; $display("FAIL reset_occ got=%0d want=0", occ); end
        total++; if (i_idle !== 1'b1) begin bad++; $display("FAIL reset_i_idle got=%b want=1", i_idle); end
    endtask

    task automatic test_latency();
        logic exp_v;
        logic [CW-1:0] exp_occ;
        clear_log();
        o_prdy = 1'b1;
        i_pvld = 1'b1;
        i_pd   = 8'hA5;
        cycle();
        i_pvld = 1'b0;
        total++; if (last_acc !== 1'b1) begin bad++; $display("FAIL latency_accept got=%b want=1", last_acc); end
        for (int n = 0; n <= STAGES + 1; n++) begin
            if (n > 0) cycle();
            exp_v   = (n == STAGES - 1);
            exp_occ = (n < STAGES) ? CW'(1) : CW'(0);
            total++; if (o_pvld !== exp_v) begin bad++; $display("FAIL latency_o_pvld edge=%0d got=%b want=%b", n, o_pvld, exp_v); end
            total++; if (occ !== exp_occ) begin bad++; $display("FAIL latency_occ edge=%0d got=%0d want=%0d", n, occ, exp_occ); end
            if (exp_v) begin
                total++; if (o_pd !== 8'hA5) begin bad++; $display("FAIL latency_o_pd got=%h want=a5", o_pd); end
            end
        end
    endtask

    task automatic test_streaming();
        int drops = 0;
        int gaps  = 0;
        int seen  = 0;
        clear_log();
        o_prdy = 1'b1;
        for (int b = 0; b < 64; b++) begin
            if (i_prdy !== 1'b1) drops++;
            i_pvld = 1'b1;
            i_pd   = DW'(b);
            cycle();
            if (last_emit) seen++;
            else if (seen > 0 && seen < 64) gaps++;
        end
        i_pvld = 1'b0;
        for (int c = 0; c < STAGES + 4 && seen < 64; c++) begin
            cycle();
            if (last_emit) seen++;
            else if (seen > 0 && seen < 64) gaps++;
        end
        total++; if (drops != 0) begin bad++; $display("FAIL stream_i_prdy_drops got=%0d want=0", drops); end
        total++; if (acc_q.size() != 64) begin bad++; $display("FAIL stream_accepted got=%0d want=64", acc_q.size()); end
        total++; if (em_q.size() != 64) begin bad++; $display("FAIL stream_emitted got=%0d want=64", em_q.size()); end
        total++; if (gaps != 0) begin bad++; $display("FAIL stream_gaps got=%0d want=0", gaps); end
        for (int i = 0; i < em_q.size(); i++) begin
            total++; if (em_q[i] !== DW'(i)) begin bad++; $display("FAIL stream_order idx=%0d got=%h want=%h", i, em_q[i], DW'(i)); end
        end
    endtask

    task automatic test_backpressure();
        int ret = -1;
        clear_log();
        o_prdy = 1'b0;
        i_pvld = 1'b1;
        i_pd   = DW'($urandom);
        for (int c = 0; c < 4*CAP + 4; c++) begin
            cycle();
            if (last_acc) i_pd = DW'($urandom);
        end
        total++; if (acc_q.size() != CAP) begin bad++; $display("FAIL bp_accepted got=%0d want=%0d", acc_q.size(), CAP); end
        total++; if (occ !== CW'(CAP)) begin bad++; $display("FAIL bp_occ_full got=%0d want=%0d", occ, CAP); end
        total++; if (i_prdy !== 1'b0) begin bad++; $display("FAIL bp_i_prdy_full got=%b want=0", i_prdy); end
        total++; if (o_pvld !== 1'b1) begin bad++; $display("FAIL bp_o_pvld_full got=%b want=1", o_pvld); end
        i_pvld = 1'b0;
        o_prdy = 1'b1;
        for (int c = 1; c <= 4*CAP && (em_q.size() < CAP || ret < 0); c++) begin
            cycle();
            if (ret < 0 && i_prdy === 1'b1) ret = c;
        end
        total++; if (ret < 1 || ret > STAGES) begin bad++; $display("FAIL bp_ready_return got=%0d want=1..%0d", ret, STAGES); end
        total++; if (em_q.size() != CAP) begin bad++; $display("FAIL bp_drained got=%0d want=%0d", em_q.size(), CAP); end
        for (int i = 0; i < em_q.size() && i < acc_q.size(); i++) begin
            total++; if (em_q[i] !== acc_q[i]) begin bad++; $display("FAIL bp_order idx=%0d got=%h want=%h", i, em_q[i], acc_q[i]); end
        end
        total++; if (occ !== '0) begin bad++; $display("FAIL bp_occ_empty got=%0d want=0", occ); end
    endtask

    task automatic test_flush();
        clear_log();
        fill(3, 8'hB1);
        total++; if (occ !== CW'(3)) begin bad++; $display("FAIL flush_pre_occ got=%0d want=3", occ); end
        flush  = 1'b1;
        i_pvld = 1'b1;
        i_pd   = 8'h77;
        o_prdy = 1'b0;
        cycle();
        flush  = 1'b0;
        i_pvld = 1'b0;
        total++; if (occ !== '0) begin bad++; $display("FAIL flush_occ got=%0d want=0", occ); end
        total++; if (o_pvld !== 1'b0) begin bad++; $display("FAIL flush_o_pvld got=%b want=0", o_pvld); end
        total++; if (i_idle !== 1'b1) begin bad++; $display("FAIL flush_i_idle got=%b want=1", i_idle); end
        total++; if (i_prdy !== 1'b1) begin bad++; $display("FAIL flush_i_prdy got=%b want=1", i_prdy); end
        flush  = 1'b1;
        i_pvld = 1'b1;
        o_prdy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle();
            total++; if (occ !== '0) begin bad++; $display("FAIL flush_hold_occ cyc=%0d got=%0d want=0", c, occ); end
            total++; if (i_prdy !== 1'b1) begin bad++; $display("FAIL flush_hold_i_prdy cyc=%0d got=%b want=1", c, i_prdy); end
            total++; if (o_pvld !== 1'b0) begin bad++; $display("FAIL flush_hold_o_pvld cyc=%0d got=%b want=0", c, o_pvld); end
        end
        flush  = 1'b0;
        i_pd   = 8'h11;
        cycle();
        i_pvld = 1'b0;
        for (int c = 0; c < 4*STAGES; c++) cycle();
        total++; if (em_q.size() != 1) begin bad++; $display("FAIL flush_emitted got=%0d want=1", em_q.size()); end
        if (em_q.size() > 0) begin
            total++; if (em_q[0] !== 8'h11) begin bad++; $display("FAIL flush_next_beat got=%h want=11", em_q[0]); end
        end
    endtask

    task automatic test_random(input int n_beats);
        bit            stalled;
        logic [DW-1:0] hold_pd;
        int            cyc = 0;
        clear_log();
        flush  = 1'b0;
        i_pvld = 1'b0;
        while (acc_q.size() < n_beats && cyc < 60000) begin
            if (!(i_pvld && !last_acc)) begin
                i_pvld = 1'($urandom_range(0, 1));
                i_pd   = DW'($urandom);
            end
            o_prdy  = 1'($urandom_range(0, 1));
            stalled = o_pvld && !o_prdy;
            hold_pd = o_pd;
            cycle();
            cyc++;
            total++; if (occ !== CW'(model_occ)) begin bad++; $display("FAIL rand_occ cyc=%0d got=%0d want=%0d", cyc, occ, model_occ); end
            total++; if (i_idle !== (model_occ == 0)) begin bad++; $display("FAIL rand_i_idle cyc=%0d got=%b want=%b", cyc, i_idle, model_occ == 0); end
            if (stalled) begin
                total++;
                if (o_pvld !== 1'b1 || o_pd !== hold_pd) begin
                    bad++; $display("FAIL rand_stall_stable cyc=%0d got=%b/%h want=1/%h", cyc, o_pvld, o_pd, hold_pd);
                end
            end
        end
        i_pvld = 1'b0;
        o_prdy = 1'b1;
        for (int c = 0; c < 4*CAP && model_occ > 0; c++) cycle();
        total++; if (acc_q.size() != n_beats) begin bad++; $display("FAIL rand_accepted got=%0d want=%0d", acc_q.size(), n_beats); end
        total++; if (em_q.size() != acc_q.size()) begin bad++; $display("FAIL rand_emitted got=%0d want=%0d", em_q.size(), acc_q.size()); end
        for (int i = 0; i < em_q.size() && i < acc_q.size(); i++) begin
            total++; if (em_q[i] !== acc_q[i]) begin bad++; $display("FAIL rand_order idx=%0d got=%h want=%h", i, em_q[i], acc_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        clear_log();
        fill(3, 8'hC1);
        total++; if (occ !== CW'(3)) begin bad++; $display("FAIL rstmid_pre_occ got=%0d want=3", occ); end
        #3;
        reset_ = 1'b0;
        #1;
        total++; if (o_pvld !== 1'b0) begin bad++; $display("FAIL rstmid_o_pvld got=%b want=0", o_pvld); end
        total++; if (occ !== '0) begin bad++; $display("FAIL rstmid_occ got=%0d want=0", occ); end
        total++; if (i_prdy !== 1'b1) begin bad++; $display("FAIL rstmid_i_prdy got=%b want=1", i_prdy); end
        total++; if (i_idle !== 1'b1) begin bad++; $display("FAIL rstmid_i_idle got=%b want=1", i_idle); end
        total++; if (o_pd !== '0) begin bad++; $display("FAIL rstmid_o_pd got=%h want=0", o_pd); end
        @(posedge sysclk_slcg);
        #1;
        reset_    = 1'b1;
        model_occ = 0;
        clear_log();
        o_prdy = 1'b1;
        for (int c = 0; c < 4*STAGES; c++) cycle();
        total++; if (em_q.size() != 0) begin bad++; $display("FAIL rstmid_no_survivor got=%0d want=0", em_q.size()); end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_ = 1'b0;
        i_pvld = 1'b0;
        i_pd   = '0;
        o_prdy = 1'b0;
        flush  = 1'b0;
        repeat (3) @(posedge sysclk_slcg);
        #1;
        reset_ = 1'b1;
        test_reset();
        test_latency();
        test_streaming();
        test_backpressure();
        test_flush();
        test_random(10000);
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
